multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/ctrl_pkg.sv | 93 +++++++++
 rtl/ctrl_wait_counter.sv | 32 +++
 rtl/multicycle_control.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ============================================================================
// ctrl_pkg : state encoding, ALU / mux select codes and opcode constants
//            shared by the multicycle control unit.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET      = 4'd0,
        ST_FETCH      = 4'd1,
        ST_FETCH_WAIT = 4'd2,
        ST_IR_WRITE   = 4'd3,
        ST_DECODE     = 4'd4,
        ST_EXEC_R     = 4'd5,
        ST_WRITE_R    = 4'd6,
        ST_ADDR_CALC  = 4'd7,
        ST_MEM_READ   = 4'd8,
        ST_LOAD_WB    = 4'd9,
        ST_MEM_WRITE  = 4'd10,
        ST_BRANCH     = 4'd11,
        ST_JUMP       = 4'd12,
        ST_LUI_WB     = 4'd13,
        ST_HALT       = 4'd14,
        ST_ILLEGAL    = 4'd15
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b110;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU     = 2'b00;
    localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

    localparam logic [1:0] M2R_ALU_OUT = 2'b00;
    localparam logic [1:0] M2R_MDR     = 2'b01;
    localparam logic [1:0] M2R_LUI     = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_NOP  = 6'h00;
    localparam logic [5:0] FN_HALT = 6'h0D;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_XOR  = 6'h26;

    typedef struct packed {
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       mdr_write;
        logic       pc_write;
        logic       write_a;
        logic       write_b;
        logic       alu_out_write;
        logic       alu_src_a;
        logic       reg_dst;
        logic       reg_write;
        logic       halted;
        logic       illegal;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    function automatic logic [2:0] r_alu_op(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_wait_counter.sv
// ============================================================================
// ctrl_wait_counter : loadable down-counter, done while the count is zero.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module ctrl_wait_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (!done) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control : FSM sequencing fetch/decode/execute for a multicycle
//                      MIPS-like datapath, with registered control outputs.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int STATE_W  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               mem_write,
    output logic               iord,
    output logic               ir_write,
    output logic               mdr_write,
    output logic               pc_write,
    output logic               write_a,
    output logic               write_b,
    output logic               alu_out_write,
    output logic               alu_src_a,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               halted,
    output logic               illegal,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic [1:0]         pc_src,
    output logic [1:0]         mem_to_reg,
    output logic [STATE_W-1:0] state_out
);

    localparam int CNT_W = $clog2(MEM_WAIT + 1);

    state_t           state;
    state_t           state_nx;
    ctrl_t            ctrl;
    ctrl_t            ctrl_nx;
    logic             wait_load;
    logic [CNT_W-1:0] wait_value;
    logic             wait_done;
    logic [CNT_W-1:0] wait_count;
    logic             branch_take;

    ctrl_wait_counter #(
        .WIDTH(CNT_W)
    ) u_wait (
        .clk       (clk),
        .reset     (reset),
        .load      (wait_load),
        .load_value(wait_value),
        .done      (wait_done),
        .count     (wait_count)
    );

    always_comb begin
        state_nx   = state;
        wait_load  = 1'b0;
        wait_value = '0;
        ctrl_nx    = '0;

        case (state)
            ST_RESET: state_nx = ST_FETCH;
            ST_FETCH: begin
                state_nx   = ST_FETCH_WAIT;
                wait_load  = 1'b1;
                wait_value = CNT_W'(MEM_WAIT - 1);
            end
            ST_FETCH_WAIT: if (wait_done) state_nx = ST_IR_WRITE;
            ST_IR_WRITE:   state_nx = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_AND, FN_XOR: state_nx = ST_EXEC_R;
                            FN_NOP:                         state_nx = ST_FETCH;
                            FN_HALT:                        state_nx = ST_HALT;
                            default:                        state_nx = ST_ILLEGAL;
                        endcase
                    end
                    OP_LW, OP_SW:   state_nx = ST_ADDR_CALC;
                    OP_BEQ, OP_BNE: state_nx = ST_BRANCH;
                    OP_LUI:         state_nx = ST_LUI_WB;
                    OP_J:           state_nx = ST_JUMP;
                    default:        state_nx = ST_ILLEGAL;
                endcase
            end
            ST_EXEC_R: state_nx = ST_WRITE_R;
            ST_ADDR_CALC: begin
                if (opcode == OP_LW) begin
                    state_nx   = ST_MEM_READ;
                    wait_load  = 1'b1;
                    wait_value = CNT_W'(MEM_WAIT);
                end else begin
                    state_nx = ST_MEM_WRITE;
                end
            end
            ST_MEM_READ: if (wait_done) state_nx = ST_LOAD_WB;
            ST_HALT:     state_nx = ST_HALT;
            default:     state_nx = ST_FETCH;
        endcase

        // Outputs are a function of the state being entered, so they line up with it once registered.
        case (state_nx)
            ST_IR_WRITE: begin
                ctrl_nx.ir_write    = 1'b1;
                ctrl_nx.pc_write    = 1'b1;
                ctrl_nx.pc_src      = PC_SRC_ALU;
                ctrl_nx.alu_src_b   = SRC_B_FOUR;
                ctrl_nx.alu_control = ALU_ADD;
            end
            ST_DECODE: begin
                ctrl_nx.write_a       = 1'b1;
                ctrl_nx.write_b       = 1'b1;
                ctrl_nx.alu_out_write = 1'b1;
                ctrl_nx.alu_src_b     = SRC_B_IMM_SH;
                ctrl_nx.alu_control   = ALU_ADD;
            end
            ST_EXEC_R: begin
                ctrl_nx.alu_src_a     = 1'b1;
                ctrl_nx.alu_src_b     = SRC_B_REG;
                ctrl_nx.alu_control   = r_alu_op(funct);
                ctrl_nx.alu_out_write = 1'b1;
            end
            ST_WRITE_R: begin
                ctrl_nx.reg_write  = 1'b1;
                ctrl_nx.reg_dst    = 1'b1;
                ctrl_nx.mem_to_reg = M2R_ALU_OUT;
            end
            ST_ADDR_CALC: begin
                ctrl_nx.alu_src_a     = 1'b1;
                ctrl_nx.alu_src_b     = SRC_B_IMM;
                ctrl_nx.alu_control   = ALU_ADD;
                ctrl_nx.alu_out_write = 1'b1;
            end
            ST_MEM_READ: begin
                ctrl_nx.iord      = 1'b1;
                // A count of one now means the next cycle is the last of the read.
                ctrl_nx.mdr_write = (state == ST_MEM_READ) && (wait_count == CNT_W'(1));
            end
            ST_LOAD_WB: begin
                ctrl_nx.reg_write  = 1'b1;
                ctrl_nx.mem_to_reg = M2R_MDR;
            end
            ST_MEM_WRITE: begin
                ctrl_nx.iord      = 1'b1;
                ctrl_nx.mem_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_nx.alu_src_a   = 1'b1;
                ctrl_nx.alu_src_b   = SRC_B_REG;
                ctrl_nx.alu_control = ALU_SUB;
                ctrl_nx.pc_src      = PC_SRC_ALU_OUT;
            end
            ST_JUMP: begin
                ctrl_nx.pc_write = 1'b1;
                ctrl_nx.pc_src   = PC_SRC_JUMP;
            end
            ST_LUI_WB: begin
                ctrl_nx.reg_write  = 1'b1;
                ctrl_nx.mem_to_reg = M2R_LUI;
            end
            ST_HALT:    ctrl_nx.halted  = 1'b1;
            ST_ILLEGAL: ctrl_nx.illegal = 1'b1;
            default:    ctrl_nx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RESET;
            ctrl  <= '0;
        end else begin
            state <= state_nx;
            ctrl  <= ctrl_nx;
        end
    end

    // The zero flag is only valid while BRANCH is subtracting, so the branch decision is taken live.
    assign branch_take = (state == ST_BRANCH) && ((opcode == OP_BNE) ? !zero : zero);

    assign mem_write     = ctrl.mem_write;
    assign iord          = ctrl.iord;
    assign ir_write      = ctrl.ir_write;
    assign mdr_write     = ctrl.mdr_write;
    assign pc_write      = ctrl.pc_write | branch_take;
    assign write_a       = ctrl.write_a;
    assign write_b       = ctrl.write_b;
    assign alu_out_write = ctrl.alu_out_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign halted        = ctrl.halted;
    assign illegal       = ctrl.illegal;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_control   = ctrl.alu_control;
    assign pc_src        = ctrl.pc_src;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign state_out     = STATE_W'(state);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control : scoreboard bench, two instances (MEM_WAIT 1 and 3).
// Revision              : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [5:0] opcode, funct;
    logic       zero;

    always #5 clk = ~clk;

    logic       a_mw, a_io, a_irw, a_mdr, a_pcw, a_wa, a_wb, a_aow, a_sa, a_rd, a_rw, a_h, a_il;
    logic [1:0] a_sb, a_pcs, a_m2r;
    logic [2:0] a_alu;
    logic [5:0] a_st;
    logic       b_mw, b_io, b_irw, b_mdr, b_pcw, b_wa, b_wb, b_aow, b_sa, b_rd, b_rw, b_h, b_il;
    logic [1:0] b_sb, b_pcs, b_m2r;
    logic [2:0] b_alu;
    logic [5:0] b_st;

    multicycle_control #(.MEM_WAIT(1), .STATE_W(6)) dut_a (
        .clk(clk), .reset(rst_a), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_write(a_mw), .iord(a_io), .ir_write(a_irw), .mdr_write(a_mdr), .pc_write(a_pcw),
        .write_a(a_wa), .write_b(a_wb), .alu_out_write(a_aow), .alu_src_a(a_sa), .reg_dst(a_rd),
        .reg_write(a_rw), .halted(a_h), .illegal(a_il), .alu_src_b(a_sb), .alu_control(a_alu),
        .pc_src(a_pcs), .mem_to_reg(a_m2r), .state_out(a_st)
    );

    multicycle_control #(.MEM_WAIT(3), .STATE_W(6)) dut_b (
        .clk(clk), .reset(rst_b), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_write(b_mw), .iord(b_io), .ir_write(b_irw), .mdr_write(b_mdr), .pc_write(b_pcw),
        .write_a(b_wa), .write_b(b_wb), .alu_out_write(b_aow), .alu_src_a(b_sa), .reg_dst(b_rd),
        .reg_write(b_rw), .halted(b_h), .illegal(b_il), .alu_src_b(b_sb), .alu_control(b_alu),
        .pc_src(b_pcs), .mem_to_reg(b_m2r), .state_out(b_st)
    );

    logic [27:0] sig_a, sig_b;
    assign sig_a = {a_st, a_mw, a_io, a_irw, a_mdr, a_pcw, a_wa, a_wb, a_aow, a_sa, a_rd, a_rw,
                    a_h, a_il, a_sb, a_alu, a_pcs, a_m2r};
    assign sig_b = {b_st, b_mw, b_io, b_irw, b_mdr, b_pcw, b_wa, b_wb, b_aow, b_sa, b_rd, b_rw,
                    b_h, b_il, b_sb, b_alu, b_pcs, b_m2r};

    typedef struct {
        bit          b;
        logic [27:0] sig;
        bit          chk;
        logic [1:0]  cnt;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   failed   = 0;

    // Expected output vector for one state, written straight from the state table.
    function automatic logic [27:0] exp_sig(int st, logic [2:0] alu, bit flag);
        logic mw = 0, io = 0, irw = 0, mdr = 0, pcw = 0, wa = 0, wb = 0, aow = 0;
        logic sa = 0, rd = 0, rw = 0, h = 0, il = 0;
        logic [1:0] sb = 2'b00, pcs = 2'b00, m2r = 2'b00;
        logic [2:0] a = 3'b000;
        case (st)
            3:  begin irw = 1; pcw = 1; sb = 2'b01; a = 3'b001; end
            4:  begin wa = 1; wb = 1; aow = 1; sb = 2'b11; a = 3'b001; end
            5:  begin sa = 1; a = alu; aow = 1; end
            6:  begin rw = 1; rd = 1; end
            7:  begin sa = 1; sb = 2'b10; a = 3'b001; aow = 1; end
            8:  begin io = 1; mdr = flag; end
            9:  begin rw = 1; m2r = 2'b01; end
            10: begin io = 1; mw = 1; end
            11: begin sa = 1; a = 3'b010; pcs = 2'b01; pcw = flag; end
            12: begin pcw = 1; pcs = 2'b10; end
            13: begin rw = 1; m2r = 2'b10; end
            14: h = 1;
            15: il = 1;
            default: ;
        endcase
        return {6'(st), mw, io, irw, mdr, pcw, wa, wb, aow, sa, rd, rw, h, il, sb, a, pcs, m2r};
    endfunction

    task automatic push(bit b, int st, string tag, logic [2:0] alu = 3'b000, bit flag = 1'b0,
                        bit chk = 1'b0, logic [1:0] cnt = 2'd0);
        exp_t e;
        e.b = b; e.sig = exp_sig(st, alu, flag); e.chk = chk; e.cnt = cnt; e.tag = tag;
        q.push_back(e);
    endtask

    // RESET, FETCH, FETCH_WAIT x MEM_WAIT, IR_WRITE, DECODE.
    task automatic push_front_end(bit b, string tag);
        int n = b ? 3 : 1;
        push(b, 0, tag);
        push(b, 1, tag);
        for (int i = 0; i < n; i++) push(b, 2, tag, 3'b000, 1'b0, b, 2'(n - 1 - i));
        push(b, 3, tag);
        push(b, 4, tag);
    endtask

    task automatic start(bit b, logic [5:0] op, logic [5:0] fn, logic z);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        opcode = op; funct = fn; zero = z;
        repeat (2) @(posedge clk);
        #1;
        if (b) rst_b = 1'b1; else rst_a = 1'b1;
    endtask

    task automatic drain(string tag);
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            failed++;
            $display("FAIL %s_timeout: %0d entries left, required 0", tag, q.size());
            q.delete();
        end
    endtask

    exp_t        mon_e;
    logic [27:0] mon_act;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e   = q.pop_front();
            mon_act = mon_e.b ? sig_b : sig_a;
            compared++;
            if (mon_act !== mon_e.sig) begin
                failed++;
                $display("FAIL %s: outputs got %h required %h", mon_e.tag, mon_act, mon_e.sig);
            end
            if (mon_e.chk) begin
                compared++;
                if (dut_b.u_wait.count !== mon_e.cnt) begin
                    failed++;
                    $display("FAIL %s_cnt: count got %0d required %0d", mon_e.tag,
                             dut_b.u_wait.count, mon_e.cnt);
                end
            end
        end
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
        @(posedge clk); #1;
        push(0, 0, "reset_a");
        push(1, 0, "reset_b", 3'b000, 1'b0, 1'b1, 2'd0);
        drain("reset");

        start(0, 6'h00, 6'h20, 1'b0);
        push_front_end(0, "r_add");
        push(0, 5, "r_add", 3'b001); push(0, 6, "r_add"); push(0, 1, "r_add");
        drain("r_add");

        start(0, 6'h00, 6'h22, 1'b0);
        push_front_end(0, "r_sub");
        push(0, 5, "r_sub", 3'b010); push(0, 6, "r_sub"); push(0, 1, "r_sub");
        drain("r_sub");

        start(0, 6'h00, 6'h26, 1'b0);
        push_front_end(0, "r_xor");
        push(0, 5, "r_xor", 3'b110); push(0, 6, "r_xor"); push(0, 1, "r_xor");
        drain("r_xor");

        start(0, 6'h04, 6'h00, 1'b1);
        push_front_end(0, "beq");
        push(0, 11, "beq", 3'b000, 1'b1); push(0, 1, "beq");
        drain("beq");

        start(0, 6'h05, 6'h00, 1'b1);
        push_front_end(0, "bne");
        push(0, 11, "bne", 3'b000, 1'b0); push(0, 1, "bne");
        drain("bne");

        start(0, 6'h3F, 6'h00, 1'b0);
        push_front_end(0, "illegal");
        push(0, 15, "illegal"); push(0, 1, "illegal");
        drain("illegal");

        start(0, 6'h00, 6'h0D, 1'b0);
        push_front_end(0, "halt");
        for (int i = 0; i < 20; i++) push(0, 14, "halt");
        drain("halt");
        #1; rst_a = 1'b0;
        push(0, 0, "halt_reset");
        drain("halt_reset");

        start(1, 6'h23, 6'h00, 1'b0);
        push_front_end(1, "lw");
        push(1, 7, "lw");
        for (int i = 0; i < 4; i++) push(1, 8, "lw", 3'b000, (i == 3), 1'b1, 2'(3 - i));
        push(1, 9, "lw"); push(1, 1, "lw");
        drain("lw");

        start(1, 6'h2B, 6'h00, 1'b0);
        push_front_end(1, "sw");
        push(1, 7, "sw"); push(1, 10, "sw"); push(1, 1, "sw");
        drain("sw");

        start(1, 6'h00, 6'h20, 1'b0);
        push(1, 0, "mid_wait"); push(1, 1, "mid_wait");
        push(1, 2, "mid_wait", 3'b000, 1'b0, 1'b1, 2'd2);
        drain("mid_wait");
        #1; rst_b = 1'b0;
        push(1, 0, "wait_reset", 3'b000, 1'b0, 1'b1, 2'd0);
        drain("wait_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

`default_nettype wire
